// File: rtl/sync_counter4.sv
// sync_counter4 -- cascadable synchronous up/down counter with parallel load.
// Q is the only state. TC is a combinational terminal-count flag and is also
// the carry-out. Feed it to the EN of the next stage to build wider counters.

module sync_counter4 #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             LD,
   input  logic             UP,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             TC
);

   // Reject widths outside the supported range when the design is elaborated.
   if ((WIDTH < 2) || (WIDTH > 8)) begin : g_width_check
      $error("sync_counter4: WIDTH must be in 2..8");
   end

   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] next_q_s;
   logic             at_max_s;
   logic             at_min_s;
   logic             tc_s;

   // All-ones detect written as a flat AND. The tool maps it to a shallow
   // NAND/NOR tree, which is at most two levels for these widths.
   function automatic logic detect_all_ones(input logic [WIDTH-1:0] v);
      logic acc;
      acc = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         acc = acc & v[i];
      end
      return acc;
   endfunction

   // All-zeros detect, the mirror of detect_all_ones.
   function automatic logic detect_all_zero(input logic [WIDTH-1:0] v);
      logic acc;
      acc = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         acc = acc & ~v[i];
      end
      return acc;
   endfunction

   // Modular step in either direction. Wrap-around needs no special case.
   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v,
                                             input logic             up);
      logic [WIDTH-1:0] r;
      if (up) begin
         r = v + ONE;
      end else begin
         r = v - ONE;
      end
      return r;
   endfunction

   // Next-count selection. Load wins over counting. LD=0 with EN=0 holds Q.
   always_comb begin
      next_q_s = q_r;
      case ({LD, EN})
         2'b10, 2'b11: next_q_s = D;
         2'b01:        next_q_s = step(q_r, UP);
         2'b00:        next_q_s = q_r;
         default:      next_q_s = q_r;
      endcase
   end

   // Count register. Reset is asynchronous and clears the count at once.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         q_r <= ALL_ZERO;
      end else begin
         q_r <= next_q_s;
      end
   end

   // Terminal count uses only EN, UP and the current count, never LD or D,
   // so a cascade of stages ripples through combinational carry only.
   always_comb begin
      at_max_s = detect_all_ones(q_r);
      at_min_s = detect_all_zero(q_r);
      if (UP) begin
         tc_s = EN & at_max_s;
      end else begin
         tc_s = EN & at_min_s;
      end
   end

   assign Q  = q_r;
   assign TC = tc_s;

endmodule
